// File: rtl/mix_column_engine_if.sv
// Block-level handshake bundle for mix_column_engine: an input channel
// (state + mode) and an output channel (transformed state).
interface mix_column_engine_if;
  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the producer holds valid and payload stable until then, and ready may
  // depend combinationally on the other channel but never on its own valid.
  logic            in_valid;
  logic            in_ready;
  logic            mode;
  logic [0:15][7:0] state_array_in;
  logic            out_valid;
  logic            out_ready;
  logic [0:15][7:0] state_array_out;

  modport master (
    output in_valid, mode, state_array_in, out_ready,
    input  in_ready, out_valid, state_array_out
  );

  modport slave (
    input  in_valid, mode, state_array_in, out_ready,
    output in_ready, out_valid, state_array_out
  );
endinterface

// File: rtl/mix_column_engine.sv
// Sequential MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Define MIX_COLUMN_INV_EN to build the inverse datapath; otherwise mode is ignored.
module mix_column_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  mix_column_engine_if.slave  bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_OFS = 2'(COLS_PER_CYCLE - 1);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Column word: bits [31:24] are row 0.
  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

`ifdef MIX_COLUMN_INV_EN
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0]  a  [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return r;
  endfunction
`endif

  state_t           state_q, state_n;
  logic [1:0]       cnt_q, cnt_n;
  logic [0:3][31:0] cols_q, cols_n;
  logic [0:3][31:0] out_q, out_n;
  logic             mode_q, mode_n;
  logic [31:0]      mix_out [COLS_PER_CYCLE];

  // cnt_q is always a multiple of COLS_PER_CYCLE, so OR-ing the lane offset
  // addresses the j-th column of the current group.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_mix
    localparam logic [1:0] OFS = 2'(j);
`ifdef MIX_COLUMN_INV_EN
    assign mix_out[j] = mode_q ? mix_inv(cols_q[cnt_q | OFS]) : mix_fwd(cols_q[cnt_q | OFS]);
`else
    assign mix_out[j] = mix_fwd(cols_q[cnt_q | OFS]);
`endif
  end

`ifndef MIX_COLUMN_INV_EN
  logic unused_mode;
  assign unused_mode = mode_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cols_q  <= '0;
      out_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      cols_q  <= cols_n;
      out_q   <= out_n;
      mode_q  <= mode_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    cols_n       = cols_q;
    out_n        = out_q;
    mode_n       = mode_q;
    bus.in_ready = 1'b0;
    case (state_q)
      IDLE: bus.in_ready = 1'b1;
      BUSY: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          cols_n[cnt_q | 2'(j)] = mix_out[j];
        end
        cnt_n = cnt_q + STEP;
        if ((cnt_q | LAST_OFS) == 2'd3) begin
          state_n = DONE;
          out_n   = cols_n;
        end
      end
      DONE: begin
        bus.in_ready = bus.out_ready;
        if (bus.out_ready && !bus.in_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A drain in DONE and a fresh load share one edge.
    if (bus.in_valid && bus.in_ready) begin
      cols_n  = bus.state_array_in;
      mode_n  = bus.mode;
      cnt_n   = '0;
      state_n = BUSY;
    end
  end

  assign bus.out_valid       = (state_q == DONE);
  assign bus.state_array_out = out_q;
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_mix_column_engine.sv
// Directed bench for mix_column_engine: three instances (1, 2, 4 columns per
// cycle) share stimulus; the 1-column instance carries the handshake scenarios.
module tb_mix_column_engine;

  localparam logic [127:0] FWD_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FWD_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] COL_B_IN  = 128'hdb135345_01010101_01010101_01010101;
  localparam logic [127:0] COL_B_OUT = 128'h8e4da1bc_01010101_01010101_01010101;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             mode;
  logic [0:15][7:0] din;
  logic             out_ready;
  logic [1:0]       dbg1, dbg2, dbg4;
  int               checks;
  int               failures;

  mix_column_engine_if b1 ();
  mix_column_engine_if b2 ();
  mix_column_engine_if b4 ();

  assign b1.in_valid = in_valid;  assign b1.mode = mode;  assign b1.state_array_in = din;  assign b1.out_ready = out_ready;
  assign b2.in_valid = in_valid;  assign b2.mode = mode;  assign b2.state_array_in = din;  assign b2.out_ready = out_ready;
  assign b4.in_valid = in_valid;  assign b4.mode = mode;  assign b4.state_array_in = din;  assign b4.out_ready = out_ready;

  mix_column_engine #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave), .state_dbg(dbg1));
  mix_column_engine #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave), .state_dbg(dbg2));
  mix_column_engine #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave), .state_dbg(dbg4));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

`ifndef MIX_COLUMN_INV_EN
  // Forward MixColumns via generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = (aa[7]) ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model_fwd(input logic [127:0] s);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   acc;
    logic [127:0] r;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[k], a[(i+k)%4]);
        r[127 - 32*c - 8*i -: 8] = acc;
      end
    end
    return r;
  endfunction
`endif

  // driver tasks
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    din       = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    mode      = 1'b0;
    checks++;
    if (b1.out_valid !== 1'b0 || b2.out_valid !== 1'b0 || b4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain out_valid got %b%b%b required 000", b1.out_valid, b2.out_valid, b4.out_valid);
    end
  endtask

  // Accept one block, optionally toggling mode while busy, then check all instances.
  task automatic run_one(input logic [127:0] data, input logic m, input logic [127:0] exp,
                         input string name, input bit toggle);
    int waited;
    din      = data;
    mode     = m;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waited   = 0;
    while (b1.out_valid !== 1'b1 && waited < 10) begin
      if (toggle) mode = ~mode;
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited != 4) begin
      failures++;
      $display("FAIL %s latency_c1 got %0d cycles required 4", name, waited);
    end
    checks++;
    if (b1.state_array_out !== exp) begin
      failures++;
      $display("FAIL %s data_c1 got %h required %h", name, b1.state_array_out, exp);
    end
    checks++;
    if (b2.state_array_out !== exp) begin
      failures++;
      $display("FAIL %s data_c2 got %h required %h", name, b2.state_array_out, exp);
    end
    checks++;
    if (b4.state_array_out !== exp) begin
      failures++;
      $display("FAIL %s data_c4 got %h required %h", name, b4.state_array_out, exp);
    end
    drain();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (b1.out_valid !== 1'b0 || b2.out_valid !== 1'b0 || b4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset out_valid got %b%b%b required 000", b1.out_valid, b2.out_valid, b4.out_valid);
    end
    checks++;
    if (b1.in_ready !== 1'b1 || b2.in_ready !== 1'b1 || b4.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset in_ready got %b%b%b required 111", b1.in_ready, b2.in_ready, b4.in_ready);
    end
    checks++;
    if (b1.state_array_out !== 128'h0 || b2.state_array_out !== 128'h0 || b4.state_array_out !== 128'h0) begin
      failures++;
      $display("FAIL reset data got %h required 0", b1.state_array_out);
    end
    checks++;
    if (dbg1 !== 2'd0 || dbg2 !== 2'd0 || dbg4 !== 2'd0) begin
      failures++;
      $display("FAIL reset fsm got %0d/%0d/%0d required 0", dbg1, dbg2, dbg4);
    end
  endtask

  task automatic test_forward();
    logic exp_v;
    din      = FWD_IN;
    mode     = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_v = (k >= 1);
      checks++;
      if (b4.out_valid !== exp_v) begin
        failures++;
        $display("FAIL fwd_latency_c4 k=%0d got %b required %b", k, b4.out_valid, exp_v);
      end
      exp_v = (k >= 2);
      checks++;
      if (b2.out_valid !== exp_v) begin
        failures++;
        $display("FAIL fwd_latency_c2 k=%0d got %b required %b", k, b2.out_valid, exp_v);
      end
      exp_v = (k >= 4);
      checks++;
      if (b1.out_valid !== exp_v) begin
        failures++;
        $display("FAIL fwd_latency_c1 k=%0d got %b required %b", k, b1.out_valid, exp_v);
      end
    end
    checks++;
    if (b1.state_array_out !== FWD_OUT || b2.state_array_out !== FWD_OUT || b4.state_array_out !== FWD_OUT) begin
      failures++;
      $display("FAIL fwd_data got %h/%h/%h required %h", b1.state_array_out, b2.state_array_out,
               b4.state_array_out, FWD_OUT);
    end
    drain();
  endtask

  task automatic test_inverse();
`ifdef MIX_COLUMN_INV_EN
    run_one(FWD_OUT, 1'b1, FWD_IN, "inverse", 1'b0);
`else
    run_one(FWD_OUT, 1'b1, model_fwd(FWD_OUT), "inverse_disabled", 1'b0);
`endif
  endtask

  task automatic test_single_column();
    run_one(COL_B_IN, 1'b0, COL_B_OUT, "col0", 1'b0);
    run_one(128'h01010101_f20a225c_01010101_01010101, 1'b0,
            128'h01010101_9fdc589d_01010101_01010101, "col1", 1'b0);
    run_one(128'h01010101_01010101_c6c6c6c6_01010101, 1'b0,
            128'h01010101_01010101_c6c6c6c6_01010101, "col2", 1'b0);
    run_one(128'h01010101_01010101_01010101_2d26314c, 1'b0,
            128'h01010101_01010101_01010101_4d7ebdf8, "col3", 1'b0);
  endtask

  task automatic test_back_to_back();
    din      = FWD_IN;
    mode     = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    din      = COL_B_IN;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (b1.out_valid !== 1'b1 || b1.in_ready !== 1'b0 || b1.state_array_out !== FWD_OUT) begin
        failures++;
        $display("FAIL backpressure cycle %0d got valid=%b ready=%b data=%h required valid=1 ready=0 data=%h",
                 i, b1.out_valid, b1.in_ready, b1.state_array_out, FWD_OUT);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (dbg1 !== 2'd1 || b1.out_valid !== 1'b0 || b1.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL drain_load got fsm=%0d valid=%b ready=%b required fsm=1 valid=0 ready=0",
               dbg1, b1.out_valid, b1.in_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (b1.out_valid !== (k == 4)) begin
        failures++;
        $display("FAIL no_bubble k=%0d got %b required %b", k, b1.out_valid, (k == 4));
      end
    end
    checks++;
    if (b1.state_array_out !== COL_B_OUT || b2.state_array_out !== COL_B_OUT || b4.state_array_out !== COL_B_OUT) begin
      failures++;
      $display("FAIL second_block got %h/%h/%h required %h", b1.state_array_out, b2.state_array_out,
               b4.state_array_out, COL_B_OUT);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    din      = FWD_IN;
    mode     = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (b1.out_valid !== 1'b0 || b2.out_valid !== 1'b0 || b4.out_valid !== 1'b0 ||
        b1.in_ready !== 1'b1 || b1.state_array_out !== 128'h0 || b4.state_array_out !== 128'h0) begin
      failures++;
      $display("FAIL mid_reset got valid=%b%b%b ready=%b data=%h required valid=000 ready=1 data=0",
               b1.out_valid, b2.out_valid, b4.out_valid, b1.in_ready, b1.state_array_out);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (b1.out_valid !== 1'b0 || b2.out_valid !== 1'b0 || b4.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL aborted_block cycle %0d got %b%b%b required 000", i, b1.out_valid, b2.out_valid, b4.out_valid);
      end
    end
    run_one(COL_B_IN, 1'b0, COL_B_OUT, "after_reset", 1'b0);
  endtask

  task automatic test_mode_toggle();
    run_one(FWD_IN, 1'b0, FWD_OUT, "toggle_fwd", 1'b1);
`ifdef MIX_COLUMN_INV_EN
    run_one(FWD_OUT, 1'b1, FWD_IN, "toggle_inv", 1'b1);
`else
    run_one(FWD_IN, 1'b1, FWD_OUT, "toggle_ignored", 1'b1);
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_forward();
    test_inverse();
    test_single_column();
    test_back_to_back();
    test_reset_mid();
    test_mode_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
